// File: rtl/cpu_sequencer.sv
// cpu_sequencer: program memory plus issue timing for simple_cpu.
// Holds each instruction on `instr` for the CU cycle count of its class,
// then issues the next word with no bubble; stops on a halt word or at the
// last program address.
module cpu_sequencer #(
  parameter int unsigned INSTR_WIDTH = 20,
  parameter int unsigned PC_BITS     = 5,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prog_we,
  input  logic [PC_BITS-1:0]     prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  input  logic                   start,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   retired
);

  localparam int unsigned DEPTH = 2 ** PC_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_HALTED
  } state_e;

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_BITS-1:0]     pc_q, pc_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic [CNT_WIDTH-1:0]   ret_q, ret_d;

  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

  logic                   busy_w;
  logic [INSTR_WIDTH-1:0] mem0_w;
  logic [INSTR_WIDTH-1:0] next_w;
  logic [PC_BITS-1:0]     pc_inc_w;
  logic [CNT_WIDTH-1:0]   ret_inc_w;

  // Cycles the CU needs per class; 0 marks the halt class.
  function automatic logic [2:0] hold_of(input logic [1:0] cls);
    case (cls)
      2'b01:   return 3'd3;
      2'b10:   return 3'd4;
      2'b11:   return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  assign busy_w    = (state_q == S_PRIME) || (state_q == S_RUN);
  // A write to address 0 in the same cycle as start must be visible to start.
  assign mem0_w    = (prog_we && !busy_w && (prog_addr == '0)) ? prog_data : mem_q[0];
  assign pc_inc_w  = pc_q + PC_BITS'(1);
  assign next_w    = mem_q[pc_inc_w];
  assign ret_inc_w = (ret_q == '1) ? ret_q : ret_q + CNT_WIDTH'(1);

  // Program memory: writable only while not executing; never reset.
  always_ff @(posedge clk) begin
    if (prog_we && !busy_w) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ret_q   <= ret_d;
    end
  end

  // Next-state: start handling, hold countdown and instruction advance.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ret_d   = ret_q;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          pc_d  = '0;
          ret_d = '0;
          if (mem0_w[INSTR_WIDTH-1 -: 2] == 2'b00) begin
            instr_d = '0;
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = S_HALTED;
          end else begin
            // Extra cycle lets the CU leave its reset state first.
            instr_d = mem0_w;
            cnt_d   = hold_of(mem0_w[INSTR_WIDTH-1 -: 2]) + 3'd1;
            state_d = S_PRIME;
          end
        end
      end
      S_PRIME, S_RUN: begin
        state_d = S_RUN;
        cnt_d   = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          ret_d = ret_inc_w;
          if (pc_q == '1) begin
            instr_d = '0;
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = S_HALTED;
          end else begin
            pc_d = pc_inc_w;
            if (next_w[INSTR_WIDTH-1 -: 2] == 2'b00) begin
              instr_d = '0;
              cnt_d   = '0;
              done_d  = 1'b1;
              state_d = S_HALTED;
            end else begin
              instr_d = next_w;
              cnt_d   = hold_of(next_w[INSTR_WIDTH-1 -: 2]);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign instr   = instr_q;
  assign pc      = pc_q;
  assign busy    = busy_w;
  assign done    = done_q;
  assign retired = ret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: a trace model expands the program into the
// expected per-cycle outputs; a compare process checks every cycle.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        prog_we = 1'b0;
  logic [4:0]  prog_addr = '0;
  logic [19:0] prog_data = '0;
  logic        start = 1'b0;
  logic [19:0] instr;
  logic [4:0]  pc;
  logic        busy;
  logic        done;
  logic [7:0]  retired;

  always #5 clk = ~clk;

  cpu_sequencer #(.INSTR_WIDTH(20), .PC_BITS(5), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .instr(instr), .pc(pc),
    .busy(busy), .done(done), .retired(retired)
  );

  typedef struct packed {
    logic [19:0] instr;
    logic [4:0]  pc;
    logic        busy;
    logic        done;
    logic [7:0]  ret;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  logic [19:0] mem_m [32];
  exp_t q[$];
  exp_t cur;
  bit   chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expand the model program into one expected entry per clock after start.
  function automatic void build_trace();
    int   p = 0;
    int   n = 0;
    int   h;
    bit   first = 1'b1;
    exp_t e;
    q.delete();
    forever begin
      logic [19:0] w = mem_m[p];
      if (w[19:18] == 2'b00) begin
        e = '{instr: 20'h0, pc: 5'(p), busy: 1'b0, done: 1'b1, ret: 8'(n)};
        q.push_back(e);
        break;
      end
      h = (w[19:18] == 2'b10) ? 4 : 3;
      if (first) h++;
      first = 1'b0;
      for (int i = 0; i < h; i++) begin
        e = '{instr: w, pc: 5'(p), busy: 1'b1, done: 1'b0, ret: 8'(n)};
        q.push_back(e);
      end
      n = (n == 255) ? 255 : n + 1;
      if (p == 31) begin
        e = '{instr: 20'h0, pc: 5'(p), busy: 1'b0, done: 1'b1, ret: 8'(n)};
        q.push_back(e);
        break;
      end
      p++;
    end
  endfunction

  // Model advance: one trace entry per edge; done lasts one cycle.
  always @(posedge clk) begin
    if (rst) begin
      if (q.size() > 0) cur = q.pop_front();
      else cur.done = 1'b0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("instr", 32'(instr), 32'(cur.instr));
      chk("pc", 32'(pc), 32'(cur.pc));
      chk("busy", 32'(busy), 32'(cur.busy));
      chk("done", 32'(done), 32'(cur.done));
      chk("retired", 32'(retired), 32'(cur.ret));
    end
  end

  // Drive one cycle of controls; model honours them only when idle.
  task automatic drive(input logic we, input logic [4:0] a, input logic [19:0] d, input logic st);
    @(negedge clk);
    if (!cur.busy) begin
      if (we) mem_m[a] = d;
      if (st) build_trace();
    end
    prog_we = we; prog_addr = a; prog_data = d; start = st;
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_k);
    int k = 0;
    while (done !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(k), 32'(exp_k));
    @(negedge clk);
  endtask

  task automatic load_mixed();
    drive(1'b1, 5'd0, 20'h40100, 1'b0);
    drive(1'b1, 5'd1, 20'h80200, 1'b0);
    drive(1'b1, 5'd2, 20'hC0300, 1'b0);
    drive(1'b1, 5'd3, 20'h00000, 1'b0);
  endtask

  task automatic load_six();
    for (int i = 0; i < 6; i++) drive(1'b1, 5'(i), 20'h40000 | 20'(i * 16'h11), 1'b0);
    drive(1'b1, 5'd6, 20'h00000, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_retired", 32'(retired), 32'h0);
    cur = '0;
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;

    // std_op only
    drive(1'b1, 5'd0, 20'h40100, 1'b0);
    drive(1'b1, 5'd1, 20'h00000, 1'b0);
    drive(1'b0, 5'd0, 20'h0, 1'b1);
    wait_done("std_edges", 4);
    chk("std_retired", 32'(retired), 32'd1);
    chk("std_pc", 32'(pc), 32'd1);

    // mixed program
    load_mixed();
    drive(1'b0, 5'd0, 20'h0, 1'b1);
    wait_done("mix_edges", 11);
    chk("mix_retired", 32'(retired), 32'd3);
    chk("mix_pc", 32'(pc), 32'd3);

    // halt at address 0
    drive(1'b1, 5'd0, 20'h00000, 1'b0);
    drive(1'b0, 5'd0, 20'h0, 1'b1);
    wait_done("halt0_edges", 0);
    chk("halt0_retired", 32'(retired), 32'd0);
    chk("halt0_busy", 32'(busy), 32'd0);

    // end of memory
    for (int i = 0; i < 32; i++) drive(1'b1, 5'(i), 20'h40000 | 20'(i), 1'b0);
    drive(1'b0, 5'd0, 20'h0, 1'b1);
    wait_done("eom_edges", 97);
    chk("eom_pc", 32'(pc), 32'd31);
    chk("eom_retired", 32'(retired), 32'd32);

    // ignored controls during RUN, honoured in HALTED
    load_six();
    drive(1'b0, 5'd0, 20'h0, 1'b1);
    @(negedge clk);
    drive(1'b1, 5'd3, 20'h8ABCD, 1'b1);
    wait_done("ign_edges", 16);
    chk("ign_retired", 32'(retired), 32'd6);
    drive(1'b1, 5'd3, 20'h8ABCD, 1'b0);
    drive(1'b0, 5'd0, 20'h0, 1'b1);
    wait_done("upd_edges", 20);

    // async reset mid-run, then rerun
    drive(1'b0, 5'd0, 20'h0, 1'b1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mrst_instr", 32'(instr), 32'h0);
    chk("mrst_pc", 32'(pc), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_retired", 32'(retired), 32'h0);
    q.delete();
    cur = '0;
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 5'd0, 20'h0, 1'b1);
    wait_done("rerun_edges", 20);
    chk("rerun_retired", 32'(retired), 32'd6);

    // write to address 0 and start in the same cycle: write wins
    drive(1'b1, 5'd0, 20'h00000, 1'b1);
    wait_done("wrst_edges", 0);
    chk("wrst_retired", 32'(retired), 32'd0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
